vga_canvas_fb: RTL and testbench

VGA_CANVAS_FB -- requirements
Module: vga_canvas_fb

---
 rtl/vga_canvas_pkg.sv | 29 ++
 rtl/vga_timing.sv | 52 +++++
 rtl/vga_canvas_fb.sv | 170 +++++++++++++++++
 tb/tb_vga_canvas_fb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_canvas_pkg.sv
// Shared 640x480 timing constants, fill-FSM state encoding and the channel
// expansion helper used by vga_canvas_fb and vga_timing.
package vga_canvas_pkg;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_TOTAL      = 10'd800;

    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } fill_state_t;

    // Widen a CBITS-wide channel to 4 bits by repeating its bit pattern.
    function automatic logic [3:0] expand_ch(input logic [3:0] c, input int cbits);
        case (cbits)
            1:       return {4{c[0]}};
            2:       return {2{c[1:0]}};
            default: return c;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster timing: pixel tick from a reloading down-counter, h/v
// counters that advance on the tick, and the raw active-low syncs.
module vga_timing
    import vga_canvas_pkg::*;
#(
    parameter int CLK_DIV = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_tick,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_hsync_raw,
    output logic       o_vsync_raw
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [9:0]    r_h;
    logic [9:0]    r_v;
    logic          w_tick;

    assign w_tick = (r_div == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= DIV_LOAD;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? DIV_LOAD : r_div - DW'(1);
            if (w_tick) begin
                if (r_h == H_TOTAL - 10'd1) begin
                    r_h <= '0;
                    r_v <= (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign o_tick      = w_tick;
    assign o_h         = r_h;
    assign o_v         = r_v;
    assign o_hsync_raw = !((r_h >= H_SYNC_START) && (r_h < H_SYNC_END));
    assign o_vsync_raw = !((r_v >= V_SYNC_START) && (r_v < V_SYNC_END));

endmodule

// File: rtl/vga_canvas_fb.sv
// Cell-based VGA framebuffer with a fill sweeper and a two-tick video path.
// Optional cursor overlay: define VGA_CANVAS_CURSOR_EN.
//
// state    | meaning
// ST_CLEAR | sweeping the fill colour into every cell, one cell per clk
// ST_IDLE  | accepting cell writes and clear requests
module vga_canvas_fb
    import vga_canvas_pkg::*;
#(
    parameter int                 COLS       = 40,
    parameter int                 ROWS       = 30,
    parameter int                 CBITS      = 2,
    parameter int                 CLK_DIV    = 4,
    parameter logic [3*CBITS-1:0] INIT_COLOR = (3*CBITS)'(6'b101101),
    localparam int                XW         = $clog2(COLS),
    localparam int                YW         = $clog2(ROWS),
    localparam int                CW         = 3 * CBITS
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [CW-1:0] wr_color,
    input  logic          clr_req,
    input  logic [CW-1:0] bg_color,
    output logic          clr_busy,
    input  logic [XW-1:0] cursor_x,
    input  logic [YW-1:0] cursor_y,
    output logic          hsync,
    output logic          vsync,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue
);

    localparam int            DEPTH     = COLS * ROWS;
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [9:0]    CELL_W    = 10'(640 / COLS);
    localparam logic [9:0]    CELL_H    = 10'(480 / ROWS);

    logic          w_tick;
    logic [9:0]    w_h;
    logic [9:0]    w_v;
    logic          w_hs_raw;
    logic          w_vs_raw;

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_tick      (w_tick),
        .o_h         (w_h),
        .o_v         (w_v),
        .o_hsync_raw (w_hs_raw),
        .o_vsync_raw (w_vs_raw)
    );

    fill_state_t   r_state;
    logic [AW-1:0] r_fill_addr;
    logic [CW-1:0] r_fill_color;
    logic [CW-1:0] r_mem [DEPTH];

    logic          w_wr_fire;
    logic          w_wr_in_range;
    logic [AW-1:0] w_wr_addr;

    assign wr_ready      = (r_state == ST_IDLE) && !clr_req;
    assign clr_busy      = (r_state == ST_CLEAR);
    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign w_wr_addr     = AW'(wr_y) * COLS_A + AW'(wr_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR;
            r_fill_addr  <= '0;
            r_fill_color <= INIT_COLOR;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_fill_addr == LAST_ADDR) r_state <= ST_IDLE;
                    else                          r_fill_addr <= r_fill_addr + AW'(1);
                end
                default: begin
                    if (clr_req) begin
                        r_state      <= ST_CLEAR;
                        r_fill_addr  <= '0;
                        r_fill_color <= bg_color;
                    end
                end
            endcase
        end
    end

    // Out-of-range writes still complete the handshake but touch nothing.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)              r_mem[r_fill_addr] <= r_fill_color;
        else if (w_wr_fire && w_wr_in_range)  r_mem[w_wr_addr]   <= wr_color;
    end

    logic          w_active;
    logic [XW-1:0] w_cx;
    logic [YW-1:0] w_cy;
    logic [AW-1:0] w_rd_addr;
    logic [CW-1:0] r_rd_data;
    logic          r_act1;
    logic          r_hs1;
    logic          r_vs1;

    assign w_active  = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_cx      = XW'(w_h / CELL_W);
    assign w_cy      = YW'(w_v / CELL_H);
    assign w_rd_addr = w_active ? (AW'(w_cy) * COLS_A + AW'(w_cx)) : '0;

    always_ff @(posedge clk) begin
        if (w_tick) r_rd_data <= r_mem[w_rd_addr];
    end

    logic [3:0] w_red;
    logic [3:0] w_green;
    logic [3:0] w_blue;
    logic [3:0] w_inv;

    assign w_red   = expand_ch(4'(r_rd_data[CW-1 -: CBITS]), CBITS);
    assign w_green = expand_ch(4'(r_rd_data[2*CBITS-1 -: CBITS]), CBITS);
    assign w_blue  = expand_ch(4'(r_rd_data[CBITS-1 -: CBITS]), CBITS);

`ifdef VGA_CANVAS_CURSOR_EN
    logic r_cur1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cur1 <= 1'b0;
        else if (w_tick) r_cur1 <= w_active && (w_cx == cursor_x) && (w_cy == cursor_y);
    end

    assign w_inv = {4{r_cur1}};
`else
    logic w_cursor_unused;

    assign w_cursor_unused = ^{cursor_x, cursor_y};
    assign w_inv           = 4'b0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (w_tick) begin
            r_act1 <= w_active;
            r_hs1  <= w_hs_raw;
            r_vs1  <= w_vs_raw;
            hsync  <= r_hs1;
            vsync  <= r_vs1;
            red    <= r_act1 ? (w_red ^ w_inv)   : 4'b0000;
            green  <= r_act1 ? (w_green ^ w_inv) : 4'b0000;
            blue   <= r_act1 ? (w_blue ^ w_inv)  : 4'b0000;
        end
    end

endmodule

// File: tb/tb_vga_canvas_fb.sv
// Self-checking bench for vga_canvas_fb: fill timing, writes, clear and a
// pixel scoreboard with two-tick latency against a cell model.
`timescale 1ns/1ps
module tb_vga_canvas_fb;

    localparam int COLS    = 40;
    localparam int ROWS    = 30;
    localparam int CBITS   = 2;
    localparam int CLK_DIV = 2;
    localparam int CLK_PER = 10;
    localparam int PIX_PER = CLK_PER * CLK_DIV;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_x     = '0;
    logic [4:0] wr_y     = '0;
    logic [5:0] wr_color = '0;
    logic       clr_req  = 1'b0;
    logic [5:0] bg_color = '0;
    logic       clr_busy;
    logic [5:0] cursor_x = 6'd5;
    logic [4:0] cursor_y = 5'd0;
    logic       hsync;
    logic       vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;

    int checks = 0;
    int errors = 0;

    logic [5:0]  m_mem [COLS*ROWS];
    logic [13:0] exp_q [$];
    time         t0;
    bit          aligned = 1'b0;

    vga_canvas_fb #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .CBITS   (CBITS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_color (wr_color),
        .clr_req  (clr_req),
        .bg_color (bg_color),
        .clr_busy (clr_busy),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .hsync    (hsync),
        .vsync    (vsync),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    always #(CLK_PER/2) clk = ~clk;

    // Expected {hsync, vsync, r, g, b} for pixel idx, where idx 0 is (h=656, v=0).
    function automatic logic [13:0] exp_pix(input int idx);
        int         h;
        int         v;
        logic [5:0] c;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        h  = (656 + idx) % 800;
        v  = ((656 + idx) / 800) % 525;
        hs = !(h >= 656 && h <= 751);
        vs = !(v >= 490 && v <= 491);
        r  = 4'h0;
        g  = 4'h0;
        b  = 4'h0;
        if (h < 640 && v < 480) begin
            c = m_mem[(v / 16) * COLS + h / 16];
            r = {c[5:4], c[5:4]};
            g = {c[3:2], c[3:2]};
            b = {c[1:0], c[1:0]};
`ifdef VGA_CANVAS_CURSOR_EN
            if (h / 16 == int'(cursor_x) && v / 16 == int'(cursor_y)) begin
                r = ~r;
                g = ~g;
                b = ~b;
            end
`endif
        end
        return {hs, vs, r, g, b};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({hsync, vsync} !== 2'b11) begin
            errors++;
            $display("FAIL reset_syncs: got %b expected 11", {hsync, vsync});
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
        end
        checks++;
        if ({clr_busy, wr_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_fsm: busy/ready got %b expected 10", {clr_busy, wr_ready});
        end
    endtask

    // Counts clks with clr_busy high; optionally fires an ignored clr_req mid-fill.
    task automatic count_fill(input string name, input bit pulse_clr);
        int n         = 0;
        bit ready_bad = 1'b0;
        while (clr_busy === 1'b1 && n < 2000) begin
            if (wr_ready !== 1'b0) ready_bad = 1'b1;
            if (pulse_clr && n == 5) begin
                clr_req  = 1'b1;
                bg_color = 6'b111111;
            end else begin
                clr_req = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        clr_req  = 1'b0;
        checks++;
        if (n != 1200) begin
            errors++;
            $display("FAIL %s_busy_clks: got %0d expected 1200", name, n);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL %s_ready_during_fill: got 1 expected 0", name);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after_fill: got %b expected 1", name, wr_ready);
        end
    endtask

    task automatic test_reset_midfill();
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++;
            $display("FAIL midfill_busy: got %b expected 1", clr_busy);
        end
        #2 rst_n = 1'b0;
        test_reset();
        rst_n = 1'b1;
        count_fill("post_reset", 1'b0);
        for (int i = 0; i < COLS*ROWS; i++) m_mem[i] = 6'b101101;
    endtask

    task automatic write_cell(input int x, input int y, input logic [5:0] c, input string name);
        int n = 0;
        wr_x     = 6'(x);
        wr_y     = 5'(y);
        wr_color = c;
        wr_valid = 1'b1;
        #1;
        while (wr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: wr_ready got %b expected 1", name, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        if (x < COLS && y < ROWS) m_mem[y*COLS + x] = c;
    endtask

    task automatic test_writes();
        write_cell(3, 1, 6'b110000, "wr_3_1");
        write_cell(40, 0, 6'b000011, "wr_40_0");
        write_cell(39, 0, 6'b001100, "wr_39_0");
    endtask

    task automatic test_video(input int n_pix, input string name);
        int          idx;
        int          h;
        int          hs_low = 0;
        bit          win    = 1'b0;
        logic [13:0] e;
        logic [13:0] got;
        if (!aligned) begin
            int n = 0;
            while (hsync !== 1'b0 && n < 4000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (hsync !== 1'b0) begin
                errors++;
                $display("FAIL %s_hsync_start: got %b expected 0", name, hsync);
                return;
            end
            t0      = $time;
            aligned = 1'b1;
        end else begin
            while ((($time - t0) % PIX_PER) != 0) @(negedge clk);
        end
        idx = int'(($time - t0) / PIX_PER);
        exp_q.delete();
        exp_q.push_back(exp_pix(idx));
        exp_q.push_back(exp_pix(idx + 1));
        for (int k = 0; k < n_pix; k++) begin
            exp_q.push_back(exp_pix(idx + k + 2));
            e   = exp_q.pop_front();
            got = {hsync, vsync, red, green, blue};
            h   = (656 + idx + k) % 800;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s_pixel h=%0d v=%0d: got %h expected %h", name, h,
                         ((656 + idx + k) / 800) % 525, got, e);
            end
            if (h == 656) begin
                win    = 1'b1;
                hs_low = 0;
            end
            if (hsync === 1'b0) hs_low++;
            if (h == 655 && win) begin
                checks++;
                if (hs_low != 96) begin
                    errors++;
                    $display("FAIL %s_hsync_width: got %0d expected 96", name, hs_low);
                end
            end
            repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic test_clear();
        wr_x     = 6'd3;
        wr_y     = 5'd1;
        wr_color = 6'b000011;
        wr_valid = 1'b1;
        bg_color = 6'b011011;
        clr_req  = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_vs_write_ready: got %b expected 0", wr_ready);
        end
        @(negedge clk);
        clr_req  = 1'b0;
        bg_color = 6'b000000;
        count_fill("clear", 1'b1);
        for (int i = 0; i < COLS*ROWS; i++) m_mem[i] = 6'b011011;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_reset_midfill();
        test_writes();
        test_video(144 + 19*800, "frame_a");
        test_clear();
        test_video(1700, "frame_b");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
